// File: rtl/rr_arbiter_8x3_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_arbiter_8x3_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8x3_if;

    logic                          en;
    logic [arb_pkg::N_REQ-1:0]     req;
    logic [arb_pkg::N_REQ-1:0]     gnt;
    logic [arb_pkg::IDX_W-1:0]     gnt_idx;
    logic                          gnt_valid;
    logic                          gnt_new;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, gnt_new
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, gnt_new
    );

endinterface : rr_arbiter_8x3_if

// File: rtl/rr_arbiter_8x3_priority_encoder.sv
// 8-to-3 priority encoder: lowest set bit wins; valid flags any bit set.
module priority_encoder_8x3
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] in_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic found;

    // Scan upward and latch the first set bit encountered.
    always_comb begin
        idx_o   = '0;
        found   = 1'b0;
        valid_o = |in_i;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (in_i[i] && !found) begin
                idx_o = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule : priority_encoder_8x3

// File: rtl/rr_arbiter_8x3.sv
// Round-robin arbiter for 8 requesters with bounded grant tenure.
// A rotating pointer masks off requesters below it; the masked encoder wins
// when anything is left, otherwise the unmasked encoder wraps the search.
module rr_arbiter_8x3
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter_8x3_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               new_q, new_d;

    logic [N_REQ-1:0]   masked_req;
    logic [IDX_W-1:0]   m_idx, u_idx, winner;
    logic               m_valid, u_valid;
    logic               timeout;

    // Keep only requesters at or above the pointer.
    always_comb begin
        masked_req = bus.req & ~((N_REQ'(1) << ptr_q) - N_REQ'(1));
    end

    priority_encoder_8x3 u_enc_masked (
        .in_i    (masked_req),
        .idx_o   (m_idx),
        .valid_o (m_valid)
    );

    priority_encoder_8x3 u_enc_unmasked (
        .in_i    (bus.req),
        .idx_o   (u_idx),
        .valid_o (u_valid)
    );

    // Next-state, pointer, hold counter and output decision.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        new_d   = 1'b0;
        winner  = m_valid ? m_idx : u_idx;
        timeout = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

        if (!bus.en) begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
        end else if (state_q == GRANT && bus.req[idx_q] && !timeout) begin
            // Saturating so unlimited tenure (MAX_HOLD=0) cannot wrap.
            if (!(&hold_q)) begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end else if (u_valid) begin
            state_d = GRANT;
            gnt_d   = N_REQ'(1) << winner;
            idx_d   = winner;
            valid_d = 1'b1;
            new_d   = 1'b1;
            ptr_d   = winner + IDX_W'(1);
            hold_d  = '0;
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            new_q   <= new_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_new   = new_q;

endmodule : rr_arbiter_8x3

// File: tb/tb_rr_arbiter_8x3.sv
// Self-checking bench for rr_arbiter_8x3 against a behavioural tenure model.
module tb_rr_arbiter_8x3;

    localparam int MAXH  = 8;
    localparam int BOUND = 7 * MAXH + 1;

    logic clk;
    logic rst_n;

    rr_arbiter_8x3_if bus_if ();

    rr_arbiter_8x3 #(
        .MAX_HOLD (MAXH),
        .HOLD_W   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the resource, for how long, and where the
    // round-robin search starts next.
    int         m_owner  = -1;
    int         m_tenure = 0;
    int         m_next   = 0;
    logic [7:0] m_gnt    = '0;
    int         m_idx    = 0;
    logic       m_valid  = 1'b0;
    logic       m_new    = 1'b0;
    int         wait_cnt [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [7:0] q);
        int found;
        m_new = 1'b0;
        if (!r) begin
            m_owner = -1; m_tenure = 0; m_next = 0;
            m_gnt = '0; m_idx = 0; m_valid = 1'b0;
        end else if (!e) begin
            m_owner = -1;
            m_gnt = '0; m_valid = 1'b0;
        end else if (m_owner >= 0 && q[m_owner] && m_tenure < MAXH) begin
            m_tenure++;
        end else begin
            found = -1;
            for (int k = 0; k < 8; k++) begin
                if (found < 0 && q[(m_next + k) % 8]) found = (m_next + k) % 8;
            end
            if (found >= 0) begin
                m_owner = found; m_tenure = 1;
                m_gnt = 8'(1) << found; m_idx = found;
                m_valid = 1'b1; m_new = 1'b1;
                m_next = (found + 1) % 8;
            end else begin
                m_owner = -1;
                m_gnt = '0; m_valid = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare #1 later.
    task automatic cycle(input logic r, input logic e, input logic [7:0] q);
        logic [7:0] g;
        @(negedge clk);
        rst_n      = r;
        bus_if.en  = e;
        bus_if.req = q;
        @(posedge clk);
        model_step(r, e, q);
        #1;
        g = bus_if.gnt;
        check_eq("gnt",       32'(g),                m_gnt);
        check_eq("gnt_idx",   32'(bus_if.gnt_idx),   m_idx);
        check_eq("gnt_valid", 32'(bus_if.gnt_valid), m_valid);
        check_eq("gnt_new",   32'(bus_if.gnt_new),   m_new);
        check_eq("onehot",    32'($countones(g) <= 1), 1);
        check_eq("valid_or",  32'(bus_if.gnt_valid == (|g)), 1);
        check_eq("gnt_in_req", 32'(g & ~q), 0);
        for (int i = 0; i < 8; i++) begin
            if (!r || !e || !q[i] || g[i]) wait_cnt[i] = 0;
            else wait_cnt[i]++;
            if (wait_cnt[i] > BOUND) begin
                check_eq("starve", 32'(wait_cnt[i]), BOUND);
                wait_cnt[i] = 0;
            end
        end
    endtask

    initial begin
        logic [7:0] rq;
        logic       re;
        logic       rr;

        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        rst_n = 1'b0; bus_if.en = 1'b1; bus_if.req = 8'hFF;

        // Reset holds all outputs low while everybody requests.
        cycle(1'b0, 1'b1, 8'hFF);
        cycle(1'b0, 1'b1, 8'hFF);
        check_eq("rst_gnt", 32'(bus_if.gnt), 0);

        // Two requesters alternate every MAX_HOLD cycles.
        for (int c = 1; c <= 20; c++) begin
            cycle(1'b1, 1'b1, 8'b0000_0101);
            check_eq("alt_gnt", 32'(bus_if.gnt), (c <= 8 || c > 16) ? 32'h01 : 32'h04);
        end

        // Wrap: idx7 wins after idx0 releases, then idx0 returns.
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'h81);
        check_eq("wrap_idx0", 32'(bus_if.gnt_idx), 0);
        cycle(1'b1, 1'b1, 8'h80);
        check_eq("wrap_idx7", 32'(bus_if.gnt_idx), 7);
        cycle(1'b1, 1'b1, 8'h81);
        check_eq("wrap_hold7", 32'(bus_if.gnt_idx), 7);
        cycle(1'b1, 1'b1, 8'h01);
        check_eq("wrap_back0", 32'(bus_if.gnt_idx), 0);

        // Sole requester: steady grant, new pulse every MAX_HOLD cycles.
        cycle(1'b0, 1'b1, 8'h00);
        for (int c = 1; c <= 20; c++) begin
            cycle(1'b1, 1'b1, 8'h10);
            check_eq("sole_gnt", 32'(bus_if.gnt), 32'h10);
            check_eq("sole_new", 32'(bus_if.gnt_new), (c == 1 || c == 9 || c == 17) ? 1 : 0);
        end

        // Enable low drops grant; pointer survives it.
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'h08);
        check_eq("en_idx3", 32'(bus_if.gnt_idx), 3);
        cycle(1'b1, 1'b0, 8'h08);
        check_eq("en_off_gnt", 32'(bus_if.gnt), 0);
        check_eq("en_off_valid", 32'(bus_if.gnt_valid), 0);
        cycle(1'b1, 1'b1, 8'h18);
        check_eq("en_on_idx4", 32'(bus_if.gnt_idx), 4);

        // Randomised traffic with persistent requests.
        rq = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) == 0) rq[i] = ~rq[i];
            end
            re = ($urandom_range(0, 49) != 0);
            rr = ($urandom_range(0, 499) != 0);
            cycle(rr, re, rq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_arbiter_8x3
